fpu_pipe_ctrl: RTL and testbench

// Parametrised issue/retire controller for the multi-cycle FPU datapath. Replaces the fixed
// two-cycle enable counter with a LATENCY-deep valid/tag pipeline that uses valid/ready

---
 rtl/fpu_pipe_if.sv | 29 ++
 rtl/fpu_pipe_ctrl.sv | 81 ++++++++
 tb/tb_fpu_pipe_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_pipe_if.sv
// Issue/retire handshake bundle between the FPU issuer, the pipe
// controller and the result consumer.
interface fpu_pipe_if #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
);
  logic               flush;
  logic               in_valid;
  logic [TAG_W-1:0]   in_tag;
  logic               in_ready;
  logic [LATENCY-1:0] stage_en;
  logic               out_valid;
  logic [TAG_W-1:0]   out_tag;
  logic               out_ready;
  logic [3:0]         inflight;
  logic               busy;

  modport master (
    output flush, in_valid, in_tag, out_ready,
    input  in_ready, stage_en, out_valid, out_tag,
    input  inflight, busy
  );

  modport slave (
    input  flush, in_valid, in_tag, out_ready,
    output in_ready, stage_en, out_valid, out_tag,
    output inflight, busy
  );
endinterface

// File: rtl/fpu_pipe_ctrl.sv
// Valid/tag pipeline that sequences the multi-cycle FPU datapath,
// with bubble collapse, backpressure and flush.
module fpu_pipe_ctrl #(
  parameter int LATENCY   = 2,
  parameter int TAG_W     = 4,
  parameter bit PIPELINED = 1'b1
) (
  input logic       clk,
  input logic       rst,
  fpu_pipe_if.slave bus
);
  localparam int L = LATENCY;

  logic [L-1:0]            v;
  logic [L-1:0]            en;
  logic [L-1:0]            vin;
  logic [L-1:0][TAG_W-1:0] t;
  logic [L-1:0][TAG_W-1:0] tin;
  logic                    fire;
  logic [3:0]              cnt;

  // A stage may load if it is empty or everything ahead advances.
  always_comb begin
    logic c;
    c  = bus.out_ready;
    en = '0;
    for (int k = L - 1; k >= 0; k--) begin
      c     = !v[k] | c;
      en[k] = c;
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < L; k++) begin
      cnt = cnt + 4'(v[k]);
    end
  end

  assign bus.in_ready = PIPELINED ? en[0] :
    (cnt == 4'd0) |
    ((cnt == 4'd1) & v[L-1] & bus.out_ready);

  assign fire = bus.in_valid & bus.in_ready;

  always_comb begin
    vin    = '0;
    tin    = '0;
    vin[0] = fire;
    tin[0] = bus.in_tag;
    for (int k = 1; k < L; k++) begin
      vin[k] = v[k-1];
      tin[k] = t[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      t <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (bus.flush) begin
          v[k] <= 1'b0;
        end else if (en[k]) begin
          v[k] <= vin[k];
        end
        if (en[k] & vin[k]) begin
          t[k] <= tin[k];
        end
      end
    end
  end

  // Reset also masks enables so the datapath stays quiet in reset.
  assign bus.stage_en  = rst ? '0 : (en & vin);
  assign bus.out_valid = v[L-1];
  assign bus.out_tag   = t[L-1];
  assign bus.inflight  = cnt;
  assign bus.busy      = |v;
endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Bench for fpu_pipe_ctrl: four configurations share one stimulus
// stream and are checked each cycle against an op-queue model.
module tb_fpu_pipe_ctrl;
  localparam int NI      = 4;
  localparam int LAT[NI] = '{2, 3, 2, 1};
  localparam bit PIP[NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_tag = '0;
  logic       out_ready = 1'b0;

  logic       ov   [NI];
  logic       ir   [NI];
  logic       bz   [NI];
  logic [3:0] otag [NI];
  logic [3:0] inf  [NI];
  logic [7:0] sen  [NI];

  int checks   = 0;
  int failures = 0;

  // model: ops oldest-first, each with a stage position and tag
  int n  [NI];
  int p  [NI][8];
  int tg [NI][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fpu_pipe_if #(.LATENCY(LAT[g]), .TAG_W(4)) bus ();
    fpu_pipe_ctrl #(
      .LATENCY(LAT[g]), .TAG_W(4), .PIPELINED(PIP[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.flush     = flush;
    assign bus.in_valid  = in_valid;
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = out_ready;
    assign ov[g]   = bus.out_valid;
    assign ir[g]   = bus.in_ready;
    assign bz[g]   = bus.busy;
    assign otag[g] = bus.out_tag;
    assign inf[g]  = bus.inflight;
    assign sen[g]  = 8'(bus.stage_en);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d rst out_valid", i), 32'(ov[i]), 0);
      chk($sformatf("i%0d rst out_tag", i), 32'(otag[i]), 0);
      chk($sformatf("i%0d rst in_ready", i), 32'(ir[i]), 1);
      chk($sformatf("i%0d rst inflight", i), 32'(inf[i]), 0);
      chk($sformatf("i%0d rst busy", i), 32'(bz[i]), 0);
      chk($sformatf("i%0d rst stage_en", i), 32'(sen[i]), 0);
    end
  endtask

  // One cycle: drive, check against model, advance model, clock.
  task automatic step(input bit iv, input logic [3:0] tag,
                      input bit ordy, input bit fl);
    int        L;
    int        s;
    int        ahead;
    int        m;
    int        np [8];
    bit        ov_e;
    bit        ret;
    bit        ir_e;
    bit        fire;
    logic [7:0] se;
    in_valid  = iv;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #2;
    for (int i = 0; i < NI; i++) begin
      L     = LAT[i];
      ov_e  = (n[i] > 0) && (p[i][0] == L - 1);
      ret   = ov_e && ordy;
      s     = ret ? 1 : 0;
      ahead = L;
      se    = '0;
      for (int j = s; j < n[i]; j++) begin
        np[j] = (p[i][j] + 1 < ahead - 1) ? p[i][j] + 1 : ahead - 1;
        if (np[j] != p[i][j]) se[np[j]] = 1'b1;
        ahead = np[j];
      end
      ir_e = PIP[i] ? (ahead >= 1)
                    : (n[i] == 0 || (n[i] == 1 && ret));
      fire = iv && ir_e;
      if (fire) se[0] = 1'b1;
      chk($sformatf("i%0d out_valid", i), 32'(ov[i]), 32'(ov_e));
      if (ov_e)
        chk($sformatf("i%0d out_tag", i), 32'(otag[i]), 32'(tg[i][0]));
      chk($sformatf("i%0d in_ready", i), 32'(ir[i]), 32'(ir_e));
      chk($sformatf("i%0d inflight", i), 32'(inf[i]), 32'(n[i]));
      chk($sformatf("i%0d busy", i), 32'(bz[i]), 32'(n[i] != 0));
      chk($sformatf("i%0d stage_en", i), 32'(sen[i]), 32'(se));
      m = 0;
      for (int j = s; j < n[i]; j++) begin
        p[i][m]  = np[j];
        tg[i][m] = tg[i][j];
        m++;
      end
      if (fire) begin
        p[i][m]  = 0;
        tg[i][m] = int'(tag);
        m++;
      end
      n[i] = fl ? 0 : m;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cyc);
    for (int c = 0; c < cyc; c++) step(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) n[i] = 0;
    in_valid = 1'b1;
    #1;
    chk_reset();
    @(negedge clk);
    chk_reset();
    rst      = 1'b0;
    in_valid = 1'b0;

    // single op, free-flowing output
    step(1'b1, 4'd5, 1'b1, 1'b0);
    idle(4);

    // back-to-back tags 0..5
    for (int k = 0; k < 6; k++) step(1'b1, 4'(k), 1'b1, 1'b0);
    idle(5);

    // stream into a stalled consumer, then drain
    for (int k = 0; k < 5; k++) step(1'b1, 4'(k + 8), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'h0, 1'b1, 1'b0);

    // in_valid held high with free output
    for (int k = 0; k < 8; k++) step(1'b1, 4'(k + 1), 1'b1, 1'b0);
    idle(4);

    // flush with ops in flight and a same-cycle request
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 4'd7, 1'b0, 1'b1);
    idle(4);

    // async reset mid-burst
    for (int k = 0; k < 3; k++) step(1'b1, 4'(k + 10), 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) n[i] = 0;
    step(1'b1, 4'd9, 1'b1, 1'b0);
    idle(4);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
